// File: rtl/debounce_edge.sv
// debounce_edge: debounces a synchronized level. A new level is accepted only
// after STABLE_CYCLES consecutive samples of it. Each accepted change produces a
// one-cycle rise or fall pulse. A change that reverts before acceptance counts
// as a glitch in a saturating counter.
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3,
    parameter int RESET_LEVEL   = 0,
    parameter int GLITCH_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_in,
    input  logic                    clear_glitch,
    output logic                    level_out,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]    CNT_ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]    CNT_LAST    = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_ZERO = {GLITCH_WIDTH{1'b0}};
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_ONE  = GLITCH_WIDTH'(1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX  = {GLITCH_WIDTH{1'b1}};
    localparam logic                    RESET_LVL   = (RESET_LEVEL != 0) ? 1'b1 : 1'b0;
    localparam state_t                  RESET_STATE = RESET_LVL ? STABLE_HI : STABLE_LO;

    // Saturating increment: the glitch count sticks at all-ones instead of wrapping.
    function automatic logic [GLITCH_WIDTH-1:0] sat_inc(input logic [GLITCH_WIDTH-1:0] v);
        if (v == GLITCH_MAX) begin
            sat_inc = GLITCH_MAX;
        end else begin
            sat_inc = v + GLITCH_ONE;
        end
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic                    glitch_ev;

    // Next-state logic for the debounce FSM, stability counter, pulses and glitch counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitch_ev = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync_in) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            CHK_HI: begin
                if (sync_in) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d   = STABLE_LO;
                    cnt_d     = CNT_ZERO;
                    glitch_ev = 1'b1;
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            CHK_LO: begin
                if (!sync_in) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d   = STABLE_HI;
                    cnt_d     = CNT_ZERO;
                    glitch_ev = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = CNT_ZERO;
                level_d = RESET_LVL;
            end
        endcase

        // A clear and a glitch on the same edge leave the new glitch counted.
        if (clear_glitch) begin
            if (glitch_ev) begin
                glitch_d = GLITCH_ONE;
            end else begin
                glitch_d = GLITCH_ZERO;
            end
        end else if (glitch_ev) begin
            glitch_d = sat_inc(glitch_q);
        end else begin
            glitch_d = glitch_q;
        end
    end

    // State and output registers with synchronous reset to the configured idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            cnt_q    <= CNT_ZERO;
            level_q  <= RESET_LVL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= GLITCH_ZERO;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Testbench for debounce_edge: table-driven vectors plus hand sequences,
// expected values queued on drive and compared after each rising edge.
module tb_debounce_edge;

    logic       clk;
    logic       rst0, sin0, clr0;
    logic       rst1, sin1, clr1;
    logic       lvl0, rise0, fall0;
    logic       lvl1, rise1, fall1;
    logic [7:0] gc0, gc1;

    int total;
    int passed;

    typedef struct {
        int         sel;
        string      name;
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] glitch;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       sin;
        logic       clr;
        logic       level;
        logic       rise;
        logic       fall;
        logic [7:0] glitch;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[28];

    debounce_edge #(.STABLE_CYCLES(4), .CNT_WIDTH(3), .RESET_LEVEL(0), .GLITCH_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst0), .sync_in(sin0), .clear_glitch(clr0),
        .level_out(lvl0), .rise_pulse(rise0), .fall_pulse(fall0), .glitch_cnt(gc0)
    );

    debounce_edge #(.STABLE_CYCLES(4), .CNT_WIDTH(3), .RESET_LEVEL(1), .GLITCH_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst1), .sync_in(sin1), .clear_glitch(clr1),
        .level_out(lvl1), .rise_pulse(rise1), .fall_pulse(fall1), .glitch_cnt(gc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                check({e.name, ".level"},  int'(lvl0),  int'(e.level));
                check({e.name, ".rise"},   int'(rise0), int'(e.rise));
                check({e.name, ".fall"},   int'(fall0), int'(e.fall));
                check({e.name, ".glitch"}, int'(gc0),   int'(e.glitch));
            end else begin
                check({e.name, ".level"},  int'(lvl1),  int'(e.level));
                check({e.name, ".rise"},   int'(rise1), int'(e.rise));
                check({e.name, ".fall"},   int'(fall1), int'(e.fall));
                check({e.name, ".glitch"}, int'(gc1),   int'(e.glitch));
            end
        end
    endtask

    task automatic step(input int sel, input string name, input logic r, input logic s,
                        input logic c, input logic el, input logic er, input logic ef,
                        input logic [7:0] eg);
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            rst0 = r; sin0 = s; clr0 = c;
        end else begin
            rst1 = r; sin1 = s; clr1 = c;
        end
        e.sel = sel; e.name = name; e.level = el; e.rise = er; e.fall = ef; e.glitch = eg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    initial begin
        int gm;
        total = 0;
        passed = 0;
        rst0 = 1'b1; sin0 = 1'b0; clr0 = 1'b0;
        rst1 = 1'b1; sin1 = 1'b0; clr1 = 1'b0;

        //                rst   sin   clr   lvl   rise  fall  glitch
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[26] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[27] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};

        for (int i = 0; i < 28; i++) begin
            step(0, $sformatf("vec%0d", i), vecs[i].rst, vecs[i].sin, vecs[i].clr,
                 vecs[i].level, vecs[i].rise, vecs[i].fall, vecs[i].glitch);
        end

        // Reset level 1: level high after reset, then a clean fall.
        step(1, "r1_rst_a",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_rst_b",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_stable",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_fall_1",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_fall_2",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_fall_3",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1, "r1_fall_4",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        step(1, "r1_after",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Glitch counter saturation: 256 three-sample glitches.
        step(0, "sat_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        gm = 0;
        for (int n = 0; n < 256; n++) begin
            for (int j = 0; j < 3; j++) begin
                step(0, "sat_hi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(gm));
            end
            gm = (gm < 255) ? gm + 1 : 255;
            step(0, "sat_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(gm));
        end
        check("sat_final", int'(gc0), 255);

        // Clear on the same edge as a glitch leaves one count; clear alone zeroes.
        step(0, "clr_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int n = 1; n <= 5; n++) begin
            step(0, "clr_hi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(n - 1));
            step(0, "clr_lo", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(n));
        end
        step(0, "clr_chk",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        step(0, "clr_and_glt",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        step(0, "clr_alone",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset during a rising check abandons it; the check restarts from scratch.
        step(0, "mid_rst",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_c1",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_c2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_a",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_b",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_c",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(0, "mid_rise",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(0, "mid_hold",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
